alu_mc: RTL and testbench

Multi-cycle, parametrised successor to the single-cycle ALU for the MIPS EX stage.
- Executes shift, add/sub, logic and compare ops in one cycle.
- Executes MULT/MULTU/DIV/DIVU iteratively over N cycles, writing internal HI/LO registers.
- Adds signed overflow detection, divide-by-zero and illegal-op flags.
- Uses a start/busy/done handshake so the pipeline stalls on busy.

---
 rtl/alu_mc.sv | 256 +++++++++++++++++++++++++
 tb/tb_alu_mc.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle MIPS EX-stage ALU with iterative mul/div and HI/LO registers
module alu_mc #(
  parameter int N   = 32,
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           flush,
  input  logic [4:0]     alu_op,
  input  logic [N-1:0]   s,
  input  logic [N-1:0]   t,
  input  logic [SHW-1:0] shamt,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   out,
  output logic           zero,
  output logic           overflow,
  output logic           div_zero,
  output logic           illegal
);

  localparam logic [4:0] OP_SLL   = 5'd0;
  localparam logic [4:0] OP_SRL   = 5'd1;
  localparam logic [4:0] OP_SRA   = 5'd2;
  localparam logic [4:0] OP_ADD   = 5'd3;
  localparam logic [4:0] OP_ADDU  = 5'd4;
  localparam logic [4:0] OP_SUB   = 5'd5;
  localparam logic [4:0] OP_SUBU  = 5'd6;
  localparam logic [4:0] OP_AND   = 5'd7;
  localparam logic [4:0] OP_OR    = 5'd8;
  localparam logic [4:0] OP_XOR   = 5'd9;
  localparam logic [4:0] OP_NOR   = 5'd10;
  localparam logic [4:0] OP_SLT   = 5'd11;
  localparam logic [4:0] OP_SLTU  = 5'd12;
  localparam logic [4:0] OP_MULT  = 5'd13;
  localparam logic [4:0] OP_MULTU = 5'd14;
  localparam logic [4:0] OP_DIV   = 5'd15;
  localparam logic [4:0] OP_DIVU  = 5'd16;
  localparam logic [4:0] OP_MFHI  = 5'd17;
  localparam logic [4:0] OP_MFLO  = 5'd18;
  localparam logic [4:0] OP_MTHI  = 5'd19;
  localparam logic [4:0] OP_MTLO  = 5'd20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Architectural HI/LO and the iteration state of the mul/div engines
  logic [N-1:0]   hi, lo;
  logic [N-1:0]   mcand;
  logic [2*N-1:0] prod;
  logic [N-1:0]   divisor, rem, quo;
  logic           neg_prod, neg_quo, neg_rem;
  logic [SHW-1:0] cnt;

  // Flush wins over a same-cycle start, so a flushed pipeline never launches
  logic launch, is_mul, is_div, op_signed, t_is_zero, last_iter;
  assign launch    = start && !flush;
  assign is_mul    = (alu_op == OP_MULT) || (alu_op == OP_MULTU);
  assign is_div    = (alu_op == OP_DIV)  || (alu_op == OP_DIVU);
  assign op_signed = (alu_op == OP_MULT) || (alu_op == OP_DIV);
  assign t_is_zero = (t == {N{1'b0}});
  assign last_iter = (cnt == SHW'(N - 1));

  // Signed mul/div run on magnitudes; the sign is reapplied at the end
  logic [N-1:0] s_mag, t_mag;
  assign s_mag = (op_signed && s[N-1]) ? ({N{1'b0}} - s) : s;
  assign t_mag = (op_signed && t[N-1]) ? ({N{1'b0}} - t) : t;

  // Shift-add multiplier: upper half accumulates, lower half holds the multiplier
  logic [N-1:0]   mul_addend;
  logic [N:0]     mul_sum;
  logic [2*N-1:0] prod_nxt, mul_res;
  assign mul_addend = prod[0] ? mcand : {N{1'b0}};
  assign mul_sum    = {1'b0, prod[2*N-1:N]} + {1'b0, mul_addend};
  assign prod_nxt   = {mul_sum, prod[N-1:1]};
  assign mul_res    = neg_prod ? ({(2*N){1'b0}} - prod_nxt) : prod_nxt;

  // Restoring divider: dividend bits shift into rem, quotient bits shift into quo
  logic [N:0]   rem_sh, rem_diff;
  logic [N-1:0] rem_nxt, quo_nxt, quo_res, rem_res;
  assign rem_sh   = {rem, quo[N-1]};
  assign rem_diff = rem_sh - {1'b0, divisor};
  assign rem_nxt  = rem_diff[N] ? rem_sh[N-1:0] : rem_diff[N-1:0];
  assign quo_nxt  = {quo[N-2:0], ~rem_diff[N]};
  assign quo_res  = neg_quo ? ({N{1'b0}} - quo_nxt) : quo_nxt;
  assign rem_res  = neg_rem ? ({N{1'b0}} - rem_nxt) : rem_nxt;

  logic [N-1:0] add_res, sub_res;
  assign add_res = s + t;
  assign sub_res = s - t;

  logic [N-1:0] sc_out;
  logic         sc_ovf, sc_ill;

  // Single-cycle result, overflow and illegal-op decode
  always_comb begin
    sc_out = {N{1'b0}};
    sc_ovf = 1'b0;
    sc_ill = 1'b0;
    case (alu_op)
      OP_SLL:   sc_out = t << shamt;
      OP_SRL:   sc_out = t >> shamt;
      OP_SRA:   sc_out = $signed(t) >>> shamt;
      OP_ADD: begin
        sc_out = add_res;
        sc_ovf = (s[N-1] == t[N-1]) && (add_res[N-1] != s[N-1]);
      end
      OP_ADDU:  sc_out = add_res;
      OP_SUB: begin
        sc_out = sub_res;
        sc_ovf = (s[N-1] != t[N-1]) && (sub_res[N-1] != s[N-1]);
      end
      OP_SUBU:  sc_out = sub_res;
      OP_AND:   sc_out = s & t;
      OP_OR:    sc_out = s | t;
      OP_XOR:   sc_out = s ^ t;
      OP_NOR:   sc_out = ~(s | t);
      OP_SLT:   sc_out = {{(N-1){1'b0}}, ($signed(s) < $signed(t))};
      OP_SLTU:  sc_out = {{(N-1){1'b0}}, (s < t)};
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: sc_out = {N{1'b0}};
      OP_MFHI:  sc_out = hi;
      OP_MFLO:  sc_out = lo;
      OP_MTHI, OP_MTLO: sc_out = s;
      default:  sc_ill = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode plus busy/done, both purely from the current state
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (launch) begin
          if (is_mul)                    state_nxt = ST_MUL;
          else if (is_div && !t_is_zero) state_nxt = ST_DIV;
          else                           state_nxt = ST_DONE;
        end
      end
      ST_MUL, ST_DIV: begin
        busy = 1'b1;
        if (flush)          state_nxt = ST_IDLE;
        else if (last_iter) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, mul/div iterations, HI/LO and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi       <= '0;
      lo       <= '0;
      mcand    <= '0;
      prod     <= '0;
      divisor  <= '0;
      rem      <= '0;
      quo      <= '0;
      neg_prod <= 1'b0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      cnt      <= '0;
      out      <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            if (is_mul) begin
              mcand    <= s_mag;
              prod     <= {{N{1'b0}}, t_mag};
              neg_prod <= op_signed && (s[N-1] ^ t[N-1]);
              cnt      <= '0;
            end else if (is_div && !t_is_zero) begin
              divisor  <= t_mag;
              quo      <= s_mag;
              rem      <= '0;
              neg_quo  <= op_signed && (s[N-1] ^ t[N-1]);
              neg_rem  <= op_signed && s[N-1];
              cnt      <= '0;
            end else if (is_div) begin
              // Divide by zero leaves HI/LO alone and reports the untouched LO
              out      <= lo;
              zero     <= (lo == {N{1'b0}});
              overflow <= 1'b0;
              div_zero <= 1'b1;
              illegal  <= 1'b0;
            end else begin
              out      <= sc_out;
              zero     <= (sc_out == {N{1'b0}});
              overflow <= sc_ovf;
              div_zero <= 1'b0;
              illegal  <= sc_ill;
              if (alu_op == OP_MTHI) hi <= s;
              if (alu_op == OP_MTLO) lo <= s;
            end
          end
        end
        ST_MUL: begin
          if (!flush) begin
            prod <= prod_nxt;
            cnt  <= cnt + 1'b1;
            if (last_iter) begin
              hi       <= mul_res[2*N-1:N];
              lo       <= mul_res[N-1:0];
              out      <= mul_res[N-1:0];
              zero     <= (mul_res[N-1:0] == {N{1'b0}});
              overflow <= 1'b0;
              div_zero <= 1'b0;
              illegal  <= 1'b0;
            end
          end
        end
        ST_DIV: begin
          if (!flush) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 1'b1;
            if (last_iter) begin
              hi       <= rem_res;
              lo       <= quo_res;
              out      <= quo_res;
              zero     <= (quo_res == {N{1'b0}});
              overflow <= 1'b0;
              div_zero <= 1'b0;
              illegal  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc against an arithmetic reference model
module tb_alu_mc;

  localparam int N   = 32;
  localparam int SHW = 5;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic           start = 1'b0;
  logic           flush = 1'b0;
  logic [4:0]     alu_op = '0;
  logic [N-1:0]   s = '0;
  logic [N-1:0]   t = '0;
  logic [SHW-1:0] shamt = '0;
  logic           busy, done, zero, overflow, div_zero, illegal;
  logic [N-1:0]   out;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  alu_mc #(.N(N), .SHW(SHW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush),
    .alu_op(alu_op), .s(s), .t(t), .shamt(shamt),
    .busy(busy), .done(done), .out(out), .zero(zero),
    .overflow(overflow), .div_zero(div_zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: MIPS semantics computed with 64-bit integer arithmetic
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output logic [31:0] e_out, output logic e_ovf,
                       output logic e_dz, output logic e_ill, output logic [31:0] n_hi,
                       output logic [31:0] n_lo, output int e_lat);
    longint sa, sb, ua, ub, r, q;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    e_out = '0; e_ovf = 1'b0; e_dz = 1'b0; e_ill = 1'b0;
    n_hi = m_hi; n_lo = m_lo; e_lat = 1;
    case (op)
      5'd0:  e_out = b << sh;
      5'd1:  e_out = b >> sh;
      5'd2:  begin r = sb >>> sh; e_out = r[31:0]; end
      5'd3:  begin r = sa + sb; e_out = r[31:0]; e_ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      5'd4:  e_out = a + b;
      5'd5:  begin r = sa - sb; e_out = r[31:0]; e_ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      5'd6:  e_out = a - b;
      5'd7:  e_out = a & b;
      5'd8:  e_out = a | b;
      5'd9:  e_out = a ^ b;
      5'd10: e_out = ~(a | b);
      5'd11: e_out = (sa < sb) ? 32'd1 : 32'd0;
      5'd12: e_out = (ua < ub) ? 32'd1 : 32'd0;
      5'd13: begin p = sa * sb; n_hi = p[63:32]; n_lo = p[31:0]; e_out = n_lo; e_lat = 33; end
      5'd14: begin p = ua * ub; n_hi = p[63:32]; n_lo = p[31:0]; e_out = n_lo; e_lat = 33; end
      5'd15, 5'd16: begin
        if (b == 32'd0) begin
          e_dz = 1'b1; e_out = m_lo;
        end else begin
          if (op == 5'd15) begin q = sa / sb; r = sa % sb; end
          else             begin q = ua / ub; r = ua % ub; end
          n_lo = q[31:0]; n_hi = r[31:0]; e_out = n_lo; e_lat = 33;
        end
      end
      5'd17: e_out = m_hi;
      5'd18: e_out = m_lo;
      5'd19: begin n_hi = a; e_out = a; end
      5'd20: begin n_lo = a; e_out = a; end
      default: e_ill = 1'b1;
    endcase
  endtask

  // One launch: drive start, wait (bounded) for done, compare against the model
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input string tag, output logic [31:0] got);
    logic [31:0] e_out, n_hi, n_lo;
    logic e_ovf, e_dz, e_ill;
    int e_lat, lat, nbusy;
    model(op, a, b, sh, e_out, e_ovf, e_dz, e_ill, n_hi, n_lo, e_lat);
    alu_op = op; s = a; t = b; shamt = sh; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s = $urandom; t = $urandom; shamt = 5'($urandom);
    lat = 1; nbusy = 0;
    while (!done && lat < 100) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(e_lat));
    check({tag, " busy_cycles"}, 64'(nbusy), 64'(e_lat - 1));
    check({tag, " out"}, 64'(out), 64'(e_out));
    check({tag, " flags"}, 64'({zero, overflow, div_zero, illegal}),
          64'({(e_out == 32'd0), e_ovf, e_dz, e_ill}));
    got = out;
    m_hi = n_hi; m_lo = n_lo;
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 64'({done, busy}), 64'(0));
    check({tag, " out_hold"}, 64'(out), 64'(e_out));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] got, prev_out, e_out, n_hi, n_lo;
    logic e_ovf, e_dz, e_ill;
    int e_lat, ndone;

    #2 reset_n = 1'b0;
    #1 check("reset_outputs", 64'({busy, done, out, zero, overflow, div_zero, illegal}), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_op(5'd3, 32'h7FFF_FFFF, 32'd1, 5'd0, "add_ovf", got);
    check("add_ovf_const", {32'b0, got, 31'b0, overflow}, {32'b0, 32'h8000_0000, 31'b0, 1'b1});
    do_op(5'd4, 32'h7FFF_FFFF, 32'd1, 5'd0, "addu", got);
    check("addu_no_ovf", 64'(overflow), 64'(0));
    do_op(5'd5, 32'd5, 32'd5, 5'd0, "sub_zero", got);
    check("sub_zero_flag", 64'({got, zero}), 64'({32'd0, 1'b1}));
    do_op(5'd11, 32'hFFFF_FFFF, 32'd1, 5'd0, "slt", got);
    check("slt_const", 64'(got), 64'(1));
    do_op(5'd12, 32'hFFFF_FFFF, 32'd1, 5'd0, "sltu", got);
    check("sltu_const", 64'(got), 64'(0));
    do_op(5'd2, 32'd0, 32'h8000_0000, 5'd4, "sra", got);
    check("sra_const", 64'(got), 64'(32'hF800_0000));

    do_op(5'd13, 32'hFFFF_FFFD, 32'd7, 5'd0, "mult", got);
    do_op(5'd17, 32'd0, 32'd0, 5'd0, "mfhi_mult", got);
    check("mult_hi_const", 64'(got), 64'(32'hFFFF_FFFF));
    do_op(5'd18, 32'd0, 32'd0, 5'd0, "mflo_mult", got);
    check("mult_lo_const", 64'(got), 64'(32'hFFFF_FFEB));
    do_op(5'd14, 32'hFFFF_FFFF, 32'd2, 5'd0, "multu", got);
    do_op(5'd17, 32'd0, 32'd0, 5'd0, "mfhi_multu", got);
    check("multu_hi_const", 64'(got), 64'(1));
    do_op(5'd18, 32'd0, 32'd0, 5'd0, "mflo_multu", got);
    check("multu_lo_const", 64'(got), 64'(32'hFFFF_FFFE));

    do_op(5'd15, 32'hFFFF_FFF9, 32'd2, 5'd0, "div", got);
    check("div_lo_const", 64'(got), 64'(32'hFFFF_FFFD));
    do_op(5'd17, 32'd0, 32'd0, 5'd0, "mfhi_div", got);
    check("div_hi_const", 64'(got), 64'(32'hFFFF_FFFF));
    do_op(5'd16, 32'd7, 32'd0, 5'd0, "divu_zero", got);
    check("divu_zero_flag", 64'(div_zero), 64'(1));
    do_op(5'd17, 32'd0, 32'd0, 5'd0, "mfhi_after_dz", got);
    check("dz_hi_kept", 64'(got), 64'(32'hFFFF_FFFF));
    do_op(5'd18, 32'd0, 32'd0, 5'd0, "mflo_after_dz", got);
    check("dz_lo_kept", 64'(got), 64'(32'hFFFF_FFFD));
    do_op(5'd25, $urandom, $urandom, 5'd3, "illegal", got);
    check("illegal_const", 64'({got, illegal}), 64'({32'd0, 1'b1}));

    // Flush ten cycles into a MULT: no done, HI/LO and outputs untouched
    prev_out = out;
    alu_op = 5'd13; s = $urandom; t = $urandom; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("flush_busy_before", 64'(busy), 64'(1));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_after", 64'(busy), 64'(0));
    ndone = 0;
    repeat (40) begin if (done) ndone++; @(posedge clk); #1; end
    check("flush_no_done", 64'(ndone), 64'(0));
    check("flush_out_kept", 64'(out), 64'(prev_out));
    do_op(5'd17, 32'd0, 32'd0, 5'd0, "mfhi_after_flush", got);
    do_op(5'd18, 32'd0, 32'd0, 5'd0, "mflo_after_flush", got);

    // Second start while busy must be ignored
    s = 32'h0001_2345; t = 32'hFFFF_0003; alu_op = 5'd13;
    model(5'd13, s, t, 5'd0, e_out, e_ovf, e_dz, e_ill, n_hi, n_lo, e_lat);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    alu_op = 5'd3; s = $urandom; t = $urandom; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; got = '0;
    repeat (45) begin
      if (done) begin ndone++; got = out; end
      @(posedge clk); #1;
    end
    check("restart_one_done", 64'(ndone), 64'(1));
    check("restart_out", 64'(got), 64'(e_out));
    m_hi = n_hi; m_lo = n_lo;
    do_op(5'd17, 32'd0, 32'd0, 5'd0, "mfhi_restart", got);

    for (int i = 0; i < 40; i++) begin
      do_op(5'($urandom_range(0, 24)), pick(), pick(), 5'($urandom), "random", got);
    end

    // Reset in the middle of a DIV clears everything at once
    alu_op = 5'd15; s = 32'h1234_5678; t = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1 check("reset_mid_div", 64'({busy, done, out, zero, overflow, div_zero, illegal}), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_hi = '0; m_lo = '0;
    do_op(5'd17, 32'd0, 32'd0, 5'd0, "mfhi_after_reset", got);
    check("reset_hi_const", 64'(got), 64'(0));
    do_op(5'd18, 32'd0, 32'd0, 5'd0, "mflo_after_reset", got);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
